data_memory_arbiter: RTL and testbench
======================================

Name: data_memory_arbiter

Overview:
Shares the single-ported word-addressed data memory between two requesters: port 0 is the CPU MEM stage, port 1 is a secondary master (debug loader / DMA). Sequences each access through a fixed-latency memory cycle with a registered req/ack handshake. Rejects misaligned or out-of-range addresses. Drives busy_o so the hazard unit can stall the pipeline while the memory is occupied.

Parameters:
MEM_LATENCY, 2, cycles the memory needs from address valid to read data valid (≥1)
DEPTH, 8, number of 32-bit words in the data memory
ADDR_W, 32, byte-address width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
req0_i  in  1  port 0 request, held until ack0_o
we0_i  in  1  port 0 write (1) / read (0)
addr0_i  in  ADDR_W  port 0 byte address
wdata0_i  in  32  port 0 write data
ack0_o  out  1  port 0 completion, one-cycle pulse
rdata0_o  out  32  port 0 read data, valid with ack0_o
req1_i, we1_i, addr1_i, wdata1_i, ack1_o, rdata1_o  same as port 0, for port 1
err_o  out  1  pulses with ack when the access was rejected
mem_addr_o  out  ADDR_W  word-aligned address to memory
mem_we_o  out  1  memory write strobe
mem_re_o  out  1  memory read enable
mem_wdata_o  out  32  memory write data
mem_rdata_i  in  32  memory read data
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_i low, async): state=IDLE; all outputs 0; last_grant=1, so port 0 wins the first tie; latched request regs cleared. Reset mid-access aborts it: mem_we_o/mem_re_o drop immediately and no ack is issued.
- Handshake: requester holds req/we/addr/wdata stable until it sees ack high, then drops req at the next edge. If req drops early, the access still completes and ack still pulses (protocol violation, not detected).
- FSM states:
  - IDLE: if any req is high, arbitrate:
    - only one requesting → grant it;
    - both requesting → grant the port != last_grant.
    - Latch grant, we, addr, wdata. Update last_grant.
    - If addr[1:0]!=0 or addr>>2 >= DEPTH → RESP with err flag set.
    - Otherwise → ACCESS with cnt=MEM_LATENCY-1.
  - ACCESS:
    - mem_addr_o = {addr[ADDR_W-1:2],2'b00}; mem_wdata_o = latched wdata.
    - mem_re_o=!we for every ACCESS cycle.
    - mem_we_o=we in the first ACCESS cycle only: exactly one write strobe per access.
    - cnt decrements each cycle. At cnt==0, capture mem_rdata_i (reads only) → RESP.
  - RESP:
    - ackN_o=1 for the granted port only.
    - rdataN_o = captured data, or 0 for writes/errors.
    - err_o = error flag.
    - Next state: IDLE. Mem strobes are 0 in this state.
- Timing:
  - Latency from the IDLE cycle that samples req to the ack cycle = MEM_LATENCY+1.
  - Error latency = 1.
  - Minimum spacing between grants: IDLE → ACCESS → … → RESP → IDLE, so one bubble cycle.
- rdataN_o holds its value until the next ack on that port.
- Requests arriving in ACCESS/RESP wait; no queueing beyond the held req.
- Simultaneous first requests after reset: port 0 wins. Continuous contention strictly alternates 0,1,0,1.

Decomposition:
- Shared package data_mem_arb_pkg: state enum {IDLE, ACCESS, RESP}; NUM_PORTS=2; default MEM_LATENCY/DEPTH constants.
- One sub-module: rr_arbiter2. Combinational grant from req[1:0] and last_grant; the last_grant register update stays in the parent.

Test Plan:
- Single read, MEM_LATENCY=2: memory word 3=32'hDEAD_BEEF; req0 read addr 32'h0C at cycle 0 → mem_re_o cycles 1–2, ack0_o and rdata0_o=32'hDEAD_BEEF at cycle 3; err_o=0; busy_o high cycles 1–3.
- Single write: req1 write addr 32'h04, data 32'h1234_5678 → mem_we_o high exactly one cycle (cycle 1) with mem_addr_o=32'h04; ack1_o at cycle 3; rdata1_o=0; read-back via port 0 returns 32'h1234_5678.
- Contention: req0 and req1 both asserted at cycle 0 after reset, held until ack → port 0 acked at cycle 3, port 1 acked at cycle 7. With both then re-requesting continuously, grant order is 0,1,0,1.
- Errors: req0 read addr 32'h02 → ack0_o and err_o high at cycle 1, no mem strobe. Repeat with addr 32'h20 (DEPTH=8) → same response.
- Reset mid-access: assert rst_i low during the first ACCESS cycle of a write → mem_we_o falls immediately; all outputs 0; no ack. After release, port 0 wins a tie.
- Early req drop: req1 read pulsed for one cycle only → access still runs, ack1_o pulses at cycle 3, FSM returns to IDLE.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_arb_pkg
// Shared definitions for the two-port data memory arbiter.
//   arb_state_t      : FSM state encoding (IDLE, ACCESS, RESP)
//   NUM_PORTS        : number of requesters sharing the memory
//   DEF_MEM_LATENCY  : default memory latency in cycles (>= 1)
//   DEF_DEPTH        : default number of 32-bit words in the data memory
// -----------------------------------------------------------------------------
package data_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   localparam int NUM_PORTS       = 2;
   localparam int DEF_MEM_LATENCY = 2;
   localparam int DEF_DEPTH       = 8;

   // Counter width able to hold MEM_LATENCY-1; never narrower than one bit.
   function automatic int cnt_width(input int latency);
      return (latency > 1) ? $clog2(latency) : 1;
   endfunction

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin grant. On a tie the port that did not win
// last time is chosen; a lone requester always wins.
//   req         in  [1:0]  request lines
//   last_grant  in  1      index of the most recently granted port
//   grant_valid out 1      any request present
//   grant_idx   out 1      index of the granted port (meaningful with grant_valid)
// -----------------------------------------------------------------------------
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_idx
);

   always_comb begin
      grant_valid = |req;
      if (req == 2'b11) begin
         grant_idx = ~last_grant;
      end else begin
         grant_idx = req[1];
      end
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
// Shares a single-ported, word-addressed data memory between the CPU MEM stage
// (port 0) and a secondary master (port 1). Each access runs IDLE -> ACCESS
// (MEM_LATENCY cycles) -> RESP, or IDLE -> RESP when the address is misaligned
// or beyond DEPTH words. All outputs are registered.
//   clk_i, rst_i                 clock, async active-low reset
//   reqN_i, weN_i, addrN_i,      port N request, write flag, byte address,
//   wdataN_i                     write data (held until ackN_o)
//   ackN_o, rdataN_o             port N one-cycle completion, read data
//   err_o                        pulses with ack for a rejected access
//   mem_addr_o, mem_we_o,        memory address (word aligned), write strobe,
//   mem_re_o, mem_wdata_o,       read enable, write data,
//   mem_rdata_i                  read data
//   busy_o                       high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module data_memory_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int MEM_LATENCY = DEF_MEM_LATENCY,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int ADDR_W      = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req0_i,
   input  logic              we0_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [31:0]       wdata0_i,
   output logic              ack0_o,
   output logic [31:0]       rdata0_o,
   input  logic              req1_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [31:0]       wdata1_i,
   output logic              ack1_o,
   output logic [31:0]       rdata1_o,
   output logic              err_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_we_o,
   output logic              mem_re_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i,
   output logic              busy_o
);

   localparam int CNT_W = cnt_width(MEM_LATENCY);

   // Per-port views of the request inputs.
   logic [NUM_PORTS-1:0] req_vec;
   logic [NUM_PORTS-1:0] we_vec;
   logic [ADDR_W-1:0]    addr_arr  [NUM_PORTS];
   logic [31:0]          wdata_arr [NUM_PORTS];

   assign req_vec      = {req1_i, req0_i};
   assign we_vec       = {we1_i, we0_i};
   assign addr_arr[0]  = addr0_i;
   assign addr_arr[1]  = addr1_i;
   assign wdata_arr[0] = wdata0_i;
   assign wdata_arr[1] = wdata1_i;

   // FSM and registered outputs.
   arb_state_t           state_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic                 grant_reg;
   logic                 last_grant_reg;
   logic                 we_reg;
   logic [NUM_PORTS-1:0] ack_reg;
   logic [31:0]          rdata_reg [NUM_PORTS];
   logic                 err_reg;
   logic [ADDR_W-1:0]    mem_addr_reg;
   logic                 mem_we_reg;
   logic                 mem_re_reg;
   logic [31:0]          mem_wdata_reg;
   logic                 busy_reg;

   // Arbitration and selection of the winning request.
   logic              grant_valid;
   logic              grant_idx;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;
   logic              sel_bad;

   rr_arbiter2 u_rr_arbiter2 (
      .req         (req_vec),
      .last_grant  (last_grant_reg),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   always_comb begin
      sel_we    = we_vec[grant_idx];
      sel_addr  = addr_arr[grant_idx];
      sel_wdata = wdata_arr[grant_idx];
      sel_bad   = (sel_addr[1:0] != 2'b00) ||
                  ((sel_addr >> 2) >= ADDR_W'(DEPTH));
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         grant_reg      <= 1'b0;
         last_grant_reg <= 1'b1;   // makes port 0 win the first tie
         we_reg         <= 1'b0;
         ack_reg        <= '0;
         rdata_reg[0]   <= '0;
         rdata_reg[1]   <= '0;
         err_reg        <= 1'b0;
         mem_addr_reg   <= '0;
         mem_we_reg     <= 1'b0;
         mem_re_reg     <= 1'b0;
         mem_wdata_reg  <= '0;
         busy_reg       <= 1'b0;
      end else begin
         // Pulsed outputs: high for exactly one cycle when set below.
         ack_reg    <= '0;
         err_reg    <= 1'b0;
         mem_we_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (grant_valid) begin
                  grant_reg      <= grant_idx;
                  last_grant_reg <= grant_idx;
                  we_reg         <= sel_we;
                  busy_reg       <= 1'b1;
                  if (sel_bad) begin
                     // Rejected: answer next cycle without touching memory.
                     state_reg            <= RESP;
                     ack_reg[grant_idx]   <= 1'b1;
                     err_reg              <= 1'b1;
                     rdata_reg[grant_idx] <= '0;
                  end else begin
                     state_reg     <= ACCESS;
                     cnt_reg       <= CNT_W'(MEM_LATENCY - 1);
                     mem_addr_reg  <= {sel_addr[ADDR_W-1:2], 2'b00};
                     mem_wdata_reg <= sel_wdata;
                     // Write strobe only in the first ACCESS cycle.
                     mem_we_reg    <= sel_we;
                     mem_re_reg    <= ~sel_we;
                  end
               end
            end

            ACCESS: begin
               if (cnt_reg == '0) begin
                  state_reg            <= RESP;
                  mem_re_reg           <= 1'b0;
                  ack_reg[grant_reg]   <= 1'b1;
                  rdata_reg[grant_reg] <= we_reg ? 32'h0 : mem_rdata_i;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end

            RESP: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end

            default: begin
               state_reg  <= IDLE;
               busy_reg   <= 1'b0;
               mem_re_reg <= 1'b0;
            end
         endcase
      end
   end

   assign ack0_o      = ack_reg[0];
   assign ack1_o      = ack_reg[1];
   assign rdata0_o    = rdata_reg[0];
   assign rdata1_o    = rdata_reg[1];
   assign err_o       = err_reg;
   assign mem_addr_o  = mem_addr_reg;
   assign mem_we_o    = mem_we_reg;
   assign mem_re_o    = mem_re_reg;
   assign mem_wdata_o = mem_wdata_reg;
   assign busy_o      = busy_reg;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_memory_arbiter
// Self-checking bench for data_memory_arbiter (MEM_LATENCY=2, DEPTH=8).
// Expected responses are queued when a request is driven; a monitor pops and
// compares them whenever an ack appears. Each test task checks its own timing.
// "Cycle 0" is the IDLE cycle in which a request is first presented.
// -----------------------------------------------------------------------------
module tb_data_memory_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, we0, req1, we1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic        ack0_o, ack1_o, err_o, mem_we_o, mem_re_o, busy_o;
   logic [31:0] rdata0_o, rdata1_o, mem_addr_o, mem_wdata_o, mem_rdata;

   always #5 clk = ~clk;

   data_memory_arbiter #(
      .MEM_LATENCY (2),
      .DEPTH       (8),
      .ADDR_W      (32)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .req0_i      (req0),
      .we0_i       (we0),
      .addr0_i     (addr0),
      .wdata0_i    (wdata0),
      .ack0_o      (ack0_o),
      .rdata0_o    (rdata0_o),
      .req1_i      (req1),
      .we1_i       (we1),
      .addr1_i     (addr1),
      .wdata1_i    (wdata1),
      .ack1_o      (ack1_o),
      .rdata1_o    (rdata1_o),
      .err_o       (err_o),
      .mem_addr_o  (mem_addr_o),
      .mem_we_o    (mem_we_o),
      .mem_re_o    (mem_re_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata),
      .busy_o      (busy_o)
   );

   // Memory model: combinational read, write on the clock edge.
   logic [31:0] mem_model [8];
   logic        pre_we;
   logic [2:0]  pre_addr;
   logic [31:0] pre_data;

   always @(posedge clk) begin
      if (pre_we) mem_model[pre_addr] = pre_data;
      else if (mem_we_o) mem_model[mem_addr_o[4:2]] = mem_wdata_o;
   end

   assign mem_rdata = mem_model[mem_addr_o[4:2]];

   function automatic logic [31:0] init_word(input int i);
      case (i)
         2:       return 32'hA5A5_A5A5;
         3:       return 32'hDEAD_BEEF;
         4:       return 32'h5A5A_5A5A;
         default: return 32'h1000_0000 + 32'(i);
      endcase
   endfunction

   typedef struct {
      int          port;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   assert_cnt = 0;
   int   fail_cnt   = 0;

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (ack0_o || ack1_o) begin
         int          port;
         logic [31:0] rd;
         exp_t        e;
         port = ack1_o ? 1 : 0;
         rd   = ack1_o ? rdata1_o : rdata0_o;
         assert_cnt++;
         if (sb_q.size() == 0) begin
            fail_cnt++;
            $display("FAIL unexpected_ack t=%0t ack0=%0b ack1=%0b required none", $time, ack0_o, ack1_o);
         end else begin
            e = sb_q.pop_front();
            assert_cnt++;
            if ((ack0_o && ack1_o) || port != e.port) begin
               fail_cnt++;
               $display("FAIL ack_port t=%0t got ack0=%0b ack1=%0b required port %0d", $time, ack0_o, ack1_o, e.port);
            end
            assert_cnt++;
            if (rd !== e.rdata) begin
               fail_cnt++;
               $display("FAIL rdata t=%0t port=%0d got %h required %h", $time, port, rd, e.rdata);
            end
            assert_cnt++;
            if (err_o !== e.err) begin
               fail_cnt++;
               $display("FAIL err t=%0t port=%0d got %0b required %0b", $time, port, err_o, e.err);
            end
            $display("txn t=%0t port=%0d rdata=%h err=%0b", $time, port, rd, err_o);
         end
      end
   end

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
      req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
      pre_we = 0; pre_addr = 0; pre_data = 0;
      for (int i = 0; i < 8; i++) begin
         pre_we = 1'b1; pre_addr = 3'(i); pre_data = init_word(i);
         next_cycle();
      end
      pre_we = 1'b0;
      @(negedge clk);
      assert_cnt++;
      if ({busy_o, ack0_o, ack1_o, err_o, mem_we_o, mem_re_o} !== 6'b0) begin
         fail_cnt++;
         $display("FAIL reset_ctrl got %b required 000000", {busy_o, ack0_o, ack1_o, err_o, mem_we_o, mem_re_o});
      end
      assert_cnt++;
      if (mem_addr_o !== 32'h0) begin
         fail_cnt++; $display("FAIL reset_mem_addr got %h required 0", mem_addr_o);
      end
      assert_cnt++;
      if (mem_wdata_o !== 32'h0) begin
         fail_cnt++; $display("FAIL reset_mem_wdata got %h required 0", mem_wdata_o);
      end
      assert_cnt++;
      if ((rdata0_o | rdata1_o) !== 32'h0) begin
         fail_cnt++; $display("FAIL reset_rdata got %h/%h required 0", rdata0_o, rdata1_o);
      end
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_single_read;
      sb_q.push_back('{0, 32'hDEAD_BEEF, 1'b0});
      req0 = 1; we0 = 0; addr0 = 32'h0C;
      @(negedge clk);
      assert_cnt++;
      if (busy_o !== 1'b0 || mem_re_o !== 1'b0) begin
         fail_cnt++; $display("FAIL read_cycle0 got busy=%0b re=%0b required 0/0", busy_o, mem_re_o);
      end
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         assert_cnt++;
         if (mem_re_o !== (c <= 2)) begin
            fail_cnt++; $display("FAIL read_re cycle=%0d got %0b required %0b", c, mem_re_o, (c <= 2));
         end
         assert_cnt++;
         if (busy_o !== 1'b1) begin
            fail_cnt++; $display("FAIL read_busy cycle=%0d got %0b required 1", c, busy_o);
         end
         assert_cnt++;
         if (ack0_o !== (c == 3)) begin
            fail_cnt++; $display("FAIL read_ack cycle=%0d got %0b required %0b", c, ack0_o, (c == 3));
         end
         if (c <= 2) begin
            assert_cnt++;
            if (mem_addr_o !== 32'h0C) begin
               fail_cnt++; $display("FAIL read_addr cycle=%0d got %h required 0000000c", c, mem_addr_o);
            end
         end
      end
      next_cycle();
      req0 = 0;
   endtask

   task automatic test_single_write;
      sb_q.push_back('{1, 32'h0, 1'b0});
      req1 = 1; we1 = 1; addr1 = 32'h04; wdata1 = 32'h1234_5678;
      @(negedge clk);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         assert_cnt++;
         if (mem_we_o !== (c == 1)) begin
            fail_cnt++; $display("FAIL write_we cycle=%0d got %0b required %0b", c, mem_we_o, (c == 1));
         end
         assert_cnt++;
         if (mem_re_o !== 1'b0) begin
            fail_cnt++; $display("FAIL write_re cycle=%0d got %0b required 0", c, mem_re_o);
         end
         assert_cnt++;
         if (ack1_o !== (c == 3)) begin
            fail_cnt++; $display("FAIL write_ack cycle=%0d got %0b required %0b", c, ack1_o, (c == 3));
         end
         if (c == 1) begin
            assert_cnt++;
            if (mem_addr_o !== 32'h04 || mem_wdata_o !== 32'h1234_5678) begin
               fail_cnt++; $display("FAIL write_bus got addr=%h data=%h required 00000004/12345678", mem_addr_o, mem_wdata_o);
            end
         end
      end
      next_cycle();
      req1 = 0; we1 = 0;
      // Read back through port 0.
      sb_q.push_back('{0, 32'h1234_5678, 1'b0});
      req0 = 1; we0 = 0; addr0 = 32'h04;
      @(negedge clk);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         assert_cnt++;
         if (ack0_o !== (c == 3)) begin
            fail_cnt++; $display("FAIL readback_ack cycle=%0d got %0b required %0b", c, ack0_o, (c == 3));
         end
      end
      next_cycle();
      req0 = 0;
   endtask

   task automatic test_contention;
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      sb_q.push_back('{0, 32'hA5A5_A5A5, 1'b0});
      sb_q.push_back('{1, 32'h5A5A_5A5A, 1'b0});
      sb_q.push_back('{0, 32'hA5A5_A5A5, 1'b0});
      sb_q.push_back('{1, 32'h5A5A_5A5A, 1'b0});
      req0 = 1; we0 = 0; addr0 = 32'h08;
      req1 = 1; we1 = 0; addr1 = 32'h10;
      @(negedge clk);
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         assert_cnt++;
         if (ack0_o !== (c == 3 || c == 11)) begin
            fail_cnt++; $display("FAIL contend_ack0 cycle=%0d got %0b required %0b", c, ack0_o, (c == 3 || c == 11));
         end
         assert_cnt++;
         if (ack1_o !== (c == 7 || c == 15)) begin
            fail_cnt++; $display("FAIL contend_ack1 cycle=%0d got %0b required %0b", c, ack1_o, (c == 7 || c == 15));
         end
         assert_cnt++;
         if (busy_o !== (c % 4 != 0)) begin
            fail_cnt++; $display("FAIL contend_busy cycle=%0d got %0b required %0b", c, busy_o, (c % 4 != 0));
         end
      end
      next_cycle();
      req0 = 0; req1 = 0;
   endtask

   task automatic test_errors;
      logic [31:0] bad_addr [2];
      bad_addr[0] = 32'h02;
      bad_addr[1] = 32'h20;
      for (int k = 0; k < 2; k++) begin
         sb_q.push_back('{0, 32'h0, 1'b1});
         req0 = 1; we0 = 0; addr0 = bad_addr[k];
         @(negedge clk);
         @(negedge clk);
         assert_cnt++;
         if (ack0_o !== 1'b1 || err_o !== 1'b1) begin
            fail_cnt++; $display("FAIL err_resp addr=%h got ack=%0b err=%0b required 1/1", bad_addr[k], ack0_o, err_o);
         end
         assert_cnt++;
         if (mem_re_o !== 1'b0 || mem_we_o !== 1'b0) begin
            fail_cnt++; $display("FAIL err_strobe addr=%h got re=%0b we=%0b required 0/0", bad_addr[k], mem_re_o, mem_we_o);
         end
         next_cycle();
         req0 = 0;
         @(negedge clk);
         assert_cnt++;
         if (busy_o !== 1'b0) begin
            fail_cnt++; $display("FAIL err_idle addr=%h got busy=%0b required 0", bad_addr[k], busy_o);
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_mid_access;
      req0 = 1; we0 = 1; addr0 = 32'h18; wdata0 = 32'hCAFE_F00D;
      @(negedge clk);
      @(negedge clk);
      assert_cnt++;
      if (mem_we_o !== 1'b1) begin
         fail_cnt++; $display("FAIL midrst_we_before got %0b required 1", mem_we_o);
      end
      rst_n = 1'b0;
      #1;
      assert_cnt++;
      if ({mem_we_o, mem_re_o, busy_o, ack0_o, ack1_o, err_o} !== 6'b0) begin
         fail_cnt++;
         $display("FAIL midrst_outputs got %b required 000000", {mem_we_o, mem_re_o, busy_o, ack0_o, ack1_o, err_o});
      end
      assert_cnt++;
      if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
         fail_cnt++; $display("FAIL midrst_bus got %h/%h required 0/0", mem_addr_o, mem_wdata_o);
      end
      req0 = 0; we0 = 0; wdata0 = 0;
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      assert_cnt++;
      if (mem_model[6] !== init_word(6)) begin
         fail_cnt++; $display("FAIL midrst_mem got %h required %h", mem_model[6], init_word(6));
      end
      // Tie after reset: port 0 first, then port 1.
      sb_q.push_back('{0, 32'hA5A5_A5A5, 1'b0});
      sb_q.push_back('{1, 32'h5A5A_5A5A, 1'b0});
      req0 = 1; addr0 = 32'h08;
      req1 = 1; we1 = 0; addr1 = 32'h10;
      @(negedge clk);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         assert_cnt++;
         if (ack0_o !== (c == 3) || ack1_o !== 1'b0) begin
            fail_cnt++; $display("FAIL midrst_tie cycle=%0d got ack0=%0b ack1=%0b required %0b/0", c, ack0_o, ack1_o, (c == 3));
         end
      end
      next_cycle();
      req0 = 0;
      for (int c = 4; c <= 7; c++) begin
         @(negedge clk);
         assert_cnt++;
         if (ack1_o !== (c == 7)) begin
            fail_cnt++; $display("FAIL midrst_ack1 cycle=%0d got %0b required %0b", c, ack1_o, (c == 7));
         end
      end
      next_cycle();
      req1 = 0;
   endtask

   task automatic test_early_drop;
      sb_q.push_back('{1, 32'hDEAD_BEEF, 1'b0});
      req1 = 1; we1 = 0; addr1 = 32'h0C;
      next_cycle();
      req1 = 0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         assert_cnt++;
         if (ack1_o !== (c == 3)) begin
            fail_cnt++; $display("FAIL early_ack cycle=%0d got %0b required %0b", c, ack1_o, (c == 3));
         end
      end
      @(negedge clk);
      assert_cnt++;
      if (busy_o !== 1'b0 || ack1_o !== 1'b0) begin
         fail_cnt++; $display("FAIL early_idle got busy=%0b ack1=%0b required 0/0", busy_o, ack1_o);
      end
      next_cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_read();
      test_single_write();
      test_contention();
      test_errors();
      test_reset_mid_access();
      test_early_drop();
      repeat (3) next_cycle();
      assert_cnt++;
      if (sb_q.size() != 0) begin
         fail_cnt++; $display("FAIL scoreboard_drain got %0d pending required 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
